// File: rtl/aes_result_collector.sv
// rtl/aes_result_collector.sv - captures pipelined AES core results into a valid/ready FIFO
// Optional build macro RESULT_TAG_EN adds an 8-bit issue tag (res_tag) per result.
module aes_result_collector #(
  parameter int LATENCY = 21,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [127:0]             aes_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [127:0]             res_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [6:0]               inflight
`ifdef RESULT_TAG_EN
  ,
  output logic [7:0]               res_tag
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [LATENCY-1:0] vld_pipe;
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]        rem;
  logic               capture, pop, accept;
  logic [127:0]       mem [DEPTH];

  assign capture    = vld_pipe[LATENCY-1];
  assign pop        = res_valid && res_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept     = capture && ((fill != FULL) || pop);
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  // Entries already stored that remain after this cycle's pop.
  assign rem        = fill - (AW+1)'(pop);

`ifdef RESULT_TAG_EN
  logic [7:0] tag_cnt;
  logic [7:0] tag_pipe [LATENCY];
  logic [7:0] tag_mem  [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_cnt <= '0;
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      if (in_valid) tag_cnt <= tag_cnt + 8'd1;
      tag_pipe[0] <= tag_cnt;
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= tag_pipe[LATENCY-1];
  end
`endif

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= aes_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      inflight  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef RESULT_TAG_EN
      res_tag   <= '0;
`endif
    end else begin
      vld_pipe[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      inflight <= inflight + 7'(in_valid) - 7'(capture);

      if (accept) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      fill   <= fill + (AW+1)'(accept) - (AW+1)'(pop);

      if (capture && !accept) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end

      // Head register looks ahead so a freshly pushed word is offered next cycle.
      res_valid <= (rem != '0) || accept;
      if (rem != '0) begin
        res_data <= mem[rd_ptr_nxt];
`ifdef RESULT_TAG_EN
        res_tag  <= tag_mem[rd_ptr_nxt];
`endif
      end else if (accept) begin
        res_data <= aes_out;
`ifdef RESULT_TAG_EN
        res_tag  <= tag_pipe[LATENCY-1];
`endif
      end
    end
  end

endmodule
